fib_array_engine: RTL

Parametrised multi-channel Fibonacci engine, next generation of the dual-channel Fibonacci ASIC. Computes fib(n) for CHANNELS independent indices in parallel using an iterative two-register recurrence (no stack), with a start/ready/done handshake, per-channel overflow detection with saturation, and a saturating sum across all channels. Sits at the top of the Fibonacci datapath, replacing the fixed 32-bit two-instance arrangement.

---
 rtl/fib_array_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fib_array_engine.sv
// Multi-channel iterative Fibonacci engine with saturating per-channel results
// and a saturating cross-channel total, behind a start/ready/done handshake.
module fib_array_engine #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int NBITS    = 6
) (
    input  logic                      clk,
    input  logic                      reset_button,
    input  logic                      start,
    input  logic [CHANNELS*NBITS-1:0] n_in,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] result,
    output logic [CHANNELS-1:0]       overflow,
    output logic [WIDTH-1:0]          total,
    output logic                      total_ovf
);

    localparam int SW = WIDTH + $clog2(CHANNELS) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SUM  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_a     [CHANNELS];
    logic [WIDTH-1:0]    r_b     [CHANNELS];
    logic [NBITS-1:0]    r_k     [CHANNELS];
    logic [CHANNELS-1:0] r_a_ovf;
    logic [CHANNELS-1:0] r_b_ovf;
    logic [CHANNELS*WIDTH-1:0] r_result;
    logic [CHANNELS-1:0] r_overflow;
    logic [WIDTH-1:0]    r_total;
    logic                r_total_ovf;

    logic [WIDTH:0]      w_add     [CHANNELS];
    logic [WIDTH-1:0]    w_b_nxt   [CHANNELS];
    logic [CHANNELS-1:0] w_b_ovf_nxt;
    logic [WIDTH-1:0]    w_res     [CHANNELS];
    logic [SW-1:0]       w_sum;
    logic                w_all_last;
    logic                w_sum_ovf;

    always_comb begin
        w_all_last = 1'b1;
        w_sum      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_add[i]       = {1'b0, r_a[i]} + {1'b0, r_b[i]};
            w_b_ovf_nxt[i] = r_b_ovf[i] | r_a_ovf[i] | w_add[i][WIDTH];
            w_b_nxt[i]     = w_b_ovf_nxt[i] ? '1 : w_add[i][WIDTH-1:0];
            w_res[i]       = r_a_ovf[i] ? '1 : r_a[i];
            w_sum          = w_sum + SW'(w_res[i]);
            if (r_k[i] > NBITS'(1)) begin
                w_all_last = 1'b0;
            end
        end
        // Any bit above WIDTH means the total no longer fits.
        w_sum_ovf = (|r_a_ovf) | (|w_sum[SW-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            r_state     <= ST_IDLE;
            r_a_ovf     <= '0;
            r_b_ovf     <= '0;
            r_result    <= '0;
            r_overflow  <= '0;
            r_total     <= '0;
            r_total_ovf <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_k[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_a_ovf     <= '0;
                        r_b_ovf     <= '0;
                        r_overflow  <= '0;
                        r_total_ovf <= 1'b0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_a[i] <= '0;
                            r_b[i] <= WIDTH'(1);
                            r_k[i] <= n_in[i*NBITS +: NBITS];
                        end
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (r_k[i] != '0) begin
                            r_a[i]     <= r_b[i];
                            r_a_ovf[i] <= r_b_ovf[i];
                            r_b[i]     <= w_b_nxt[i];
                            r_b_ovf[i] <= w_b_ovf_nxt[i];
                            r_k[i]     <= r_k[i] - NBITS'(1);
                        end
                    end
                    if (w_all_last) begin
                        r_state <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_result[i*WIDTH +: WIDTH] <= w_res[i];
                    end
                    r_overflow  <= r_a_ovf;
                    r_total     <= w_sum_ovf ? '1 : w_sum[WIDTH-1:0];
                    r_total_ovf <= w_sum_ovf;
                    r_state     <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_SUM);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign total     = r_total;
    assign total_ovf = r_total_ovf;

endmodule
